// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
// Helpers work on a fixed MAXW-bit vector so any WIDTH up to MAXW can use them.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t;

  localparam int unsigned MAXW = 64;

  // Rotate left by one within the low w bits; bit w-1 wraps to bit 0.
  function automatic logic [MAXW-1:0] rotl1(input logic [MAXW-1:0] v, input int unsigned w);
    logic [MAXW-1:0] mask;
    mask = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

  function automatic logic [31:0] onehot2bin(input logic [MAXW-1:0] v);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (v[i]) b = b | 32'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest set bit of req at or above the one-hot base,
// wrapping around. Returns zero when req is zero.
module rr_pick #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] pick
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] diff;
  logic [2*WIDTH-1:0] masked;

  // Subtracting the base from the doubled request isolates the first set bit at or after it.
  assign dbl    = {req, req};
  assign diff   = dbl - {{WIDTH{1'b0}}, base};
  assign masked = dbl & ~diff;
  assign pick   = masked[WIDTH-1:0] | masked[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/rr_arbiter_lock.sv
// Registered round-robin arbiter with grant locking, packet mode, burst cap and
// zero-bubble re-arbitration on release.
module rr_arbiter_lock
  import arb_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PACKET_MODE = 1,
  parameter int MAX_BEATS   = 64,
  parameter int IDXW        = $clog2(WIDTH > 1 ? WIDTH : 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             last,
  input  logic             ack,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDXW-1:0]  grant_idx,
  output logic             grant_forced
);

  localparam int CNTW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam bit PM = (PACKET_MODE != 0);
  localparam bit CAP_EN = PM && (MAX_BEATS != 0);
  localparam logic [CNTW-1:0] CAP_LAST = CNTW'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  arb_state_t       state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [CNTW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDXW-1:0]  grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             grant_forced_q, grant_forced_d;

  logic [WIDTH-1:0] grant_rot;
  logic [WIDTH-1:0] pick_idle;
  logic [WIDTH-1:0] pick_next;
  logic             beat, done, cap, abort_w, release_w;

  assign grant_rot = WIDTH'(rotl1(MAXW'(grant_q), WIDTH));

  rr_pick #(.WIDTH(WIDTH)) u_pick_idle (
    .req  (req),
    .base (base_q),
    .pick (pick_idle)
  );

  // The releasing winner is masked out so it cannot win twice in a row.
  rr_pick #(.WIDTH(WIDTH)) u_pick_next (
    .req  (req & ~grant_q),
    .base (grant_rot),
    .pick (pick_next)
  );

  assign beat      = ack;
  assign done      = beat & (!PM | last);
  assign cap       = CAP_EN & beat & (beat_cnt_q == CAP_LAST);
  assign abort_w   = ~|(req & grant_q);
  assign release_w = done | cap | abort_w;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    base_d         = base_q;
    beat_cnt_d     = beat_cnt_q;
    grant_idx_d    = grant_idx_q;
    grant_forced_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d     = pick_idle;
          grant_idx_d = IDXW'(onehot2bin(MAXW'(pick_idle)));
          beat_cnt_d  = '0;
          state_d     = ARB_GRANTED;
        end
      end
      ARB_GRANTED: begin
        if (release_w) begin
          base_d         = grant_rot;
          beat_cnt_d     = '0;
          grant_forced_d = cap & ~done;
          if (|pick_next) begin
            grant_d     = pick_next;
            grant_idx_d = IDXW'(onehot2bin(MAXW'(pick_next)));
          end else begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end else if (beat && (beat_cnt_q != '1)) begin
          beat_cnt_d = beat_cnt_q + CNTW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      grant_q        <= '0;
      base_q         <= WIDTH'(1);
      beat_cnt_q     <= '0;
      grant_idx_q    <= '0;
      grant_valid_q  <= 1'b0;
      grant_forced_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      base_q         <= base_d;
      beat_cnt_q     <= beat_cnt_d;
      grant_idx_q    <= grant_idx_d;
      grant_valid_q  <= grant_valid_d;
      grant_forced_q <= grant_forced_d;
    end
  end

  assign grant        = grant_q;
  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_forced = grant_forced_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_base_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot(base_q));
  a_valid_match:   assert property (@(posedge clk) disable iff (rst) grant_valid_q == (|grant_q));
  a_valid_owner:   assert property (@(posedge clk) disable iff (rst)
                                    grant_valid_q |-> ((|(grant_q & req)) || release_w));

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Bench for rr_arbiter_lock: three configurations share one stimulus stream and are
// checked every cycle against an index-based round-robin model, plus directed scenarios.
module tb_rr_arbiter_lock;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] req = '0;
  logic         ack = 1'b0;
  logic         last = 1'b0;

  logic [W-1:0] grant_o  [3];
  logic         valid_o  [3];
  logic [3:0]   idx_o    [3];
  logic         forced_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0: packet mode, cap 64. Instance 1: single-beat. Instance 2: packet mode, cap 4.
  rr_arbiter_lock #(.WIDTH(W), .PACKET_MODE(1), .MAX_BEATS(64)) dut_a (
    .clk(clk), .rst(rst), .req(req), .last(last), .ack(ack),
    .grant(grant_o[0]), .grant_valid(valid_o[0]), .grant_idx(idx_o[0]), .grant_forced(forced_o[0])
  );
  rr_arbiter_lock #(.WIDTH(W), .PACKET_MODE(0), .MAX_BEATS(64)) dut_b (
    .clk(clk), .rst(rst), .req(req), .last(last), .ack(ack),
    .grant(grant_o[1]), .grant_valid(valid_o[1]), .grant_idx(idx_o[1]), .grant_forced(forced_o[1])
  );
  rr_arbiter_lock #(.WIDTH(W), .PACKET_MODE(1), .MAX_BEATS(4)) dut_c (
    .clk(clk), .rst(rst), .req(req), .last(last), .ack(ack),
    .grant(grant_o[2]), .grant_valid(valid_o[2]), .grant_idx(idx_o[2]), .grant_forced(forced_o[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Model: owner and priority are plain integer indices; priority starts scanning at m_base.
  int  pm_p [3] = '{1, 0, 1};
  int  mb_p [3] = '{64, 64, 4};
  bit  m_valid  [3] = '{0, 0, 0};
  bit  m_forced [3] = '{0, 0, 0};
  int  m_idx    [3] = '{0, 0, 0};
  int  m_base   [3] = '{0, 0, 0};
  int  m_cnt    [3] = '{0, 0, 0};
  string nm [3] = '{"A", "B", "C"};

  function automatic int first_from(input logic [W-1:0] r, input int start);
    for (int i = 0; i < W; i++) begin
      int j;
      j = (start + i) % W;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input int k);
    int o;
    bit done, capv, abort, rel;
    logic [W-1:0] r2;
    m_forced[k] = 1'b0;
    if (rst) begin
      m_valid[k] = 1'b0;
      m_idx[k]   = 0;
      m_base[k]  = 0;
      m_cnt[k]   = 0;
    end else if (!m_valid[k]) begin
      if (req != '0) begin
        m_idx[k]   = first_from(req, m_base[k]);
        m_valid[k] = 1'b1;
        m_cnt[k]   = 0;
      end
    end else begin
      done  = ack && (pm_p[k] == 0 || last);
      capv  = (pm_p[k] != 0) && (mb_p[k] != 0) && ack && (m_cnt[k] == mb_p[k] - 1);
      abort = !req[m_idx[k]];
      rel   = done || capv || abort;
      if (rel) begin
        m_forced[k] = capv && !done;
        m_base[k]   = (m_idx[k] + 1) % W;
        m_cnt[k]    = 0;
        r2 = req;
        r2[m_idx[k]] = 1'b0;
        o = first_from(r2, m_base[k]);
        if (o >= 0) m_idx[k] = o;
        else m_valid[k] = 1'b0;
      end else if (ack) begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  // Single compare process: advance the model on the edge, compare shortly after.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.grant", nm[k]), 32'(grant_o[k]), m_valid[k] ? (32'd1 << m_idx[k]) : 32'd0);
      chk($sformatf("%s.grant_valid", nm[k]), 32'(valid_o[k]), 32'(m_valid[k]));
      chk($sformatf("%s.grant_idx", nm[k]), 32'(idx_o[k]), 32'(m_idx[k]));
      chk($sformatf("%s.grant_forced", nm[k]), 32'(forced_o[k]), 32'(m_forced[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ack = 1'b0; last = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset mid-burst
    req = 16'hFFFF; ack = 1'b1; last = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst1.grant", 32'(grant_o[0]), 32'h0);
    chk("rst1.valid", 32'(valid_o[0]), 32'h0);
    tick();
    chk("rst2.grant", 32'(grant_o[0]), 32'h0);
    rst = 1'b0;
    tick();
    chk("rst.base_bit0", 32'(grant_o[0]), 32'h1);

    // Single-beat fairness sweep
    do_reset();
    req = 16'hFFFF; ack = 1'b1; last = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk($sformatf("fair.idx%0d", i), 32'(idx_o[1]), 32'(i % 16));
      chk($sformatf("fair.valid%0d", i), 32'(valid_o[1]), 32'h1);
    end

    // Lock across a 5-beat packet
    do_reset();
    req = 16'h0009;
    tick();
    chk("lock.first", 32'(grant_o[0]), 32'h1);
    for (int b = 1; b <= 5; b++) begin
      ack = 1'b1; last = (b == 5);
      tick();
      chk($sformatf("lock.beat%0d", b), 32'(grant_o[0]), (b < 5) ? 32'h1 : 32'h8);
    end
    ack = 1'b0; last = 1'b0;

    // Burst cap of 4
    do_reset();
    req = 16'h0003;
    tick();
    chk("cap.first", 32'(grant_o[2]), 32'h1);
    ack = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      tick();
      chk($sformatf("cap.grant%0d", b), 32'(grant_o[2]), (b < 4) ? 32'h1 : 32'h2);
      chk($sformatf("cap.forced%0d", b), 32'(forced_o[2]), (b < 4) ? 32'h0 : 32'h1);
    end
    ack = 1'b0;
    tick();
    chk("cap.pulse_end", 32'(forced_o[2]), 32'h0);

    // Abort: winner drops its request
    do_reset();
    req = 16'h0024;
    tick();
    chk("abort.first", 32'(grant_o[0]), 32'h4);
    req = 16'h0020;
    tick();
    chk("abort.next", 32'(grant_o[0]), 32'h20);
    chk("abort.forced", 32'(forced_o[0]), 32'h0);

    // Wrap-around from bit 15 to bit 0
    do_reset();
    req = 16'h4000;
    tick();
    chk("wrap.b14", 32'(grant_o[0]), 32'h4000);
    req = 16'hC001; ack = 1'b1; last = 1'b1;
    tick();
    chk("wrap.b15", 32'(grant_o[0]), 32'h8000);
    req = 16'h8001;
    tick();
    chk("wrap.b0", 32'(grant_o[0]), 32'h1);
    chk("wrap.idx", 32'(idx_o[0]), 32'h0);
    ack = 1'b0; last = 1'b0;

    // Random soak
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: req = W'($urandom);
        1: req = req;
        2: req = W'(1) << $urandom_range(0, W - 1);
        default: req = req ^ (W'(1) << $urandom_range(0, W - 1));
      endcase
      ack  = ($urandom_range(0, 1) == 1);
      last = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0; req = '0; ack = 1'b0; last = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
